// File: rtl/reg_file.sv
// Register file for the gate/ALU datapath: 2^ADDR_W x WIDTH, one write port, two registered
// read ports with write-first bypass. Register 0 reads as zero and is never stored.
module reg_file #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [WIDTH-1:0]  ra_data,
   output logic [WIDTH-1:0]  rb_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] regs [1:DEPTH-1];
   logic             wr_en;
   logic [WIDTH-1:0] read_a;
   logic [WIDTH-1:0] read_b;

   // Writes to address 0 are dropped here so the storage array never needs an entry for it.
   assign wr_en = we && (waddr != '0);

   // The new value wins over the stored one when a port reads the address being written.
   always_comb begin
      read_a = '0;
      if (ra_addr != '0) begin
         if (wr_en && (waddr == ra_addr)) begin
            read_a = wdata;
         end else begin
            read_a = regs[ra_addr];
         end
      end
   end

   always_comb begin
      read_b = '0;
      if (rb_addr != '0) begin
         if (wr_en && (waddr == rb_addr)) begin
            read_b = wdata;
         end else begin
            read_b = regs[rb_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         ra_data <= '0;
         rb_data <= '0;
      end else begin
         if (wr_en) begin
            regs[waddr] <= wdata;
         end
         ra_data <= read_a;
         rb_data <= read_b;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: the driver pushes hand-computed read results into a queue,
// and a monitor pops and compares them one cycle later when the read data appears.
module tb_reg_file;

   localparam int WIDTH  = 4;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] ra_addr;
   logic [ADDR_W-1:0] rb_addr;
   logic [WIDTH-1:0]  ra_data;
   logic [WIDTH-1:0]  rb_data;

   logic [2*WIDTH-1:0] exp_q[$];
   string              name_q[$];
   logic               issue_chk;
   logic               mon_valid;
   int                 n_checks;
   int                 n_pass;
   bit                 stim_done;

   reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .ra_data (ra_data),
      .rb_data (rb_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // read data for an issued check becomes visible after the next edge
   always @(posedge clk) mon_valid <= issue_chk;

   // driver: one cycle of stimulus; optionally expect a read result after this edge
   task automatic step(input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic [ADDR_W-1:0] a,
                       input logic [ADDR_W-1:0] b, input logic chk, input logic [WIDTH-1:0] ea,
                       input logic [WIDTH-1:0] eb, input string nm);
      rst     = r;
      we      = w;
      waddr   = wa;
      wdata   = wd;
      ra_addr = a;
      rb_addr = b;
      issue_chk = chk;
      if (chk) begin
         exp_q.push_back({ea, eb});
         name_q.push_back(nm);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
      step(1'b0, 1'b1, wa, wd, '0, '0, 1'b0, '0, '0, "");
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                     input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb, input string nm);
      step(1'b0, 1'b0, '0, '0, a, b, 1'b1, ea, eb, nm);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (mon_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_read: got ra=%b rb=%b, required no pending read", ra_data, rb_data);
         end else begin
            logic [2*WIDTH-1:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ({ra_data, rb_data} === e) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got ra=%b rb=%b, required ra=%b rb=%b",
                        nm, ra_data, rb_data, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
            end
         end
      end
   end

   // stimulus
   initial begin
      n_checks  = 0;
      n_pass    = 0;
      stim_done = 1'b0;
      issue_chk = 1'b0;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra_addr = '0; rb_addr = '0;
      @(posedge clk);
      #1;

      step(1'b1, 1'b0, 3'd0, 4'b0000, 3'd1, 3'd2, 1'b1, 4'b0000, 4'b0000, "reset_cycle1");
      step(1'b1, 1'b0, 3'd0, 4'b0000, 3'd3, 3'd4, 1'b1, 4'b0000, 4'b0000, "reset_cycle2");
      for (int i = 1; i < 8; i++) begin
         rd(3'(i), 3'(8 - i), 4'b0000, 4'b0000, "post_reset_read");
      end

      wr(3'd1, 4'b1010);
      wr(3'd2, 4'b1100);
      rd(3'd1, 3'd2, 4'b1010, 4'b1100, "readback_r1_r2");

      step(1'b0, 1'b1, 3'd0, 4'b1111, 3'd0, 3'd0, 1'b1, 4'b0000, 4'b0000, "r0_write_bypass");
      rd(3'd0, 3'd0, 4'b0000, 4'b0000, "r0_read");

      wr(3'd3, 4'b0101);
      rd(3'd3, 3'd3, 4'b0101, 4'b0101, "r3_initial");
      step(1'b0, 1'b1, 3'd3, 4'b1010, 3'd3, 3'd3, 1'b1, 4'b1010, 4'b1010, "bypass_r3");
      rd(3'd3, 3'd3, 4'b1010, 4'b1010, "after_bypass_r3");
      step(1'b0, 1'b1, 3'd7, 4'b0111, 3'd7, 3'd1, 1'b1, 4'b0111, 4'b1010, "bypass_porta_only");

      wr(3'd2, 4'b0001);
      step(1'b0, 1'b1, 3'd2, 4'b0010, 3'd1, 3'd2, 1'b1, 4'b1010, 4'b0010, "back_to_back_bypass");
      rd(3'd2, 3'd7, 4'b0010, 4'b0111, "back_to_back_stored");
      step(1'b0, 1'b0, 3'd2, 4'b1111, 3'd2, 3'd2, 1'b1, 4'b0010, 4'b0010, "we_low_no_bypass");
      rd(3'd2, 3'd2, 4'b0010, 4'b0010, "we_low_no_write");

      step(1'b1, 1'b1, 3'd4, 4'b1111, 3'd4, 3'd1, 1'b1, 4'b0000, 4'b0000, "reset_with_write");
      rd(3'd4, 3'd1, 4'b0000, 4'b0000, "reset_priority_r4");
      rd(3'd3, 3'd7, 4'b0000, 4'b0000, "reset_cleared_r3_r7");

      wr(3'd5, 4'b0110);
      wr(3'd6, 4'b1001);
      rd(3'd5, 3'd6, 4'b0110, 4'b1001, "r5_r6_written");
      step(1'b1, 1'b0, 3'd0, 4'b0000, 3'd5, 3'd6, 1'b1, 4'b0000, 4'b0000, "mid_reset_pulse");
      rd(3'd5, 3'd6, 4'b0000, 4'b0000, "mid_reset_cleared");
      step(1'b0, 1'b1, 3'd5, 4'b0011, 3'd6, 3'd5, 1'b1, 4'b0000, 4'b0011, "rewrite_r5_bypass");
      rd(3'd5, 3'd6, 4'b0011, 4'b0000, "rewrite_r5_stored");

      step(1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 3'd0, 1'b0, 4'b0000, 4'b0000, "");
      step(1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 3'd0, 1'b0, 4'b0000, 4'b0000, "");
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: %0d reads still pending, required 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      if (!stim_done) begin
         $display("FAIL timeout: stimulus incomplete after 100000 time units, required completion");
         $display("%0d/%0d checks passed", n_pass, n_checks + 1);
         $fatal(1);
      end
   end

endmodule
